antares_divider: RTL and testbench



---
 rtl/antares_divider_pkg.sv | 17 +
 rtl/antares_cloz.sv | 26 ++
 rtl/antares_divider.sv | 163 ++++++++++++++++
 tb/tb_antares_divider.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antares_divider_pkg.sv
// Shared definitions for the antares iterative divider.
// Holds the divider FSM encoding, the datapath width and the result used for divide-by-zero.
// Imported by the divider top and its count-leading-ones/zeros helper.
package antares_divider_pkg;

    localparam int DATA_W = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/antares_cloz.sv
// Count leading ones and leading zeros of a 32-bit word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs follow A continuously.
module antares_cloz
    import antares_divider_pkg::*;
(
    input  logic [31:0] A,
    output logic [5:0]  clz_result,
    output logic [5:0]  clo_result
);

    // Scan upward so the highest matching bit sets the final count.
    always_comb begin
        clz_result = 6'd32;
        clo_result = 6'd32;
        for (int i = 0; i < DATA_W; i++) begin
            if (A[i]) begin
                clz_result = 6'(DATA_W - 1 - i);
            end
            if (!A[i]) begin
                clo_result = 6'(DATA_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/antares_divider.sv
// Radix-2 restoring divider for DIV/DIVU, skipping the dividend's leading zero bits.
// Latency: busy for (32 - clz(|dividend|)) + 1 cycles, done pulses as busy falls.
// Backpressure: starts are ignored while busy; flush aborts without a done pulse.
module antares_divider
    import antares_divider_pkg::*;
#(
    parameter bit ENABLE_EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_divs,
    input  logic        op_divu,
    input  logic        flush,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done
);

    state_t      state_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [31:0] raw_dvd_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic [32:0] rem_q;
    logic [5:0]  bits_left_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic        busy_q;
    logic        done_q;

    logic        start_req;
    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;
    logic [5:0]  clz;
    logic [5:0]  z_eff;
    logic [31:0] dvd_init;
    logic [5:0]  bits_init;
    logic [33:0] shifted;
    logic        quo_bit;
    logic [32:0] rem_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign start_req = op_divs | op_divu;

    // Magnitudes of the operands; only a signed op negates, and 0x80000000 maps to itself.
    always_comb begin
        abs_dividend = dividend;
        abs_divisor  = divisor;
        if (op_divs && dividend[31]) begin
            abs_dividend = 32'd0 - dividend;
        end
        if (op_divs && divisor[31]) begin
            abs_divisor = 32'd0 - divisor;
        end
    end

    antares_cloz u_cloz (
        .A          (abs_dividend),
        .clz_result (clz),
        .clo_result ()
    );

    // Pre-normalise the dividend so its leading zero bits need no iterations.
    always_comb begin
        z_eff     = ENABLE_EARLY_OUT ? clz : 6'd0;
        dvd_init  = (z_eff >= 6'd32) ? 32'd0 : (abs_dividend << z_eff);
        bits_init = (divisor == 32'd0) ? 6'd0 : (6'd32 - z_eff);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        shifted  = {rem_q, dvd_q[31]};
        quo_bit  = (shifted >= {2'b00, dsr_q});
        rem_next = quo_bit ? 33'(shifted - {2'b00, dsr_q}) : shifted[32:0];
    end

    // Sign correction of the final result; a zero divisor yields a fixed pattern instead.
    always_comb begin
        quo_fix = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
        rem_fix = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        if (div_zero_q) begin
            quo_fix = DIV_ZERO_QUOTIENT;
            rem_fix = raw_dvd_q;
        end
    end

    // Control FSM and datapath registers; flush beats everything except reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            raw_dvd_q   <= 32'd0;
            dvd_q       <= 32'd0;
            dsr_q       <= 32'd0;
            rem_q       <= 33'd0;
            bits_left_q <= 6'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req) begin
                            neg_quo_q   <= op_divs & (dividend[31] ^ divisor[31]);
                            neg_rem_q   <= op_divs & dividend[31];
                            div_zero_q  <= (divisor == 32'd0);
                            raw_dvd_q   <= dividend;
                            dvd_q       <= dvd_init;
                            dsr_q       <= abs_divisor;
                            rem_q       <= 33'd0;
                            bits_left_q <= bits_init;
                            busy_q      <= 1'b1;
                            // Nothing to iterate: go straight to the result cycle.
                            state_q     <= (bits_init == 6'd0) ? FIX : RUN;
                        end
                    end
                    RUN: begin
                        if (bits_left_q != 6'd0) begin
                            rem_q       <= rem_next;
                            dvd_q       <= {dvd_q[30:0], quo_bit};
                            bits_left_q <= bits_left_q - 6'd1;
                        end
                        // Leave on the edge that performs the last iteration.
                        if (bits_left_q <= 6'd1) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        quotient_q  <= quo_fix;
                        remainder_q <= rem_fix;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_antares_divider.sv
// Scoreboard bench for antares_divider: stimulus queues expected results, monitors check on done.
// A second instance with early-out disabled checks the fixed 33-cycle latency.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_antares_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        op_divs;
    logic        op_divu;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;

    logic        op_divu_ne;
    logic [31:0] quotient_ne;
    logic [31:0] remainder_ne;
    logic        busy_ne;
    logic        done_ne;

    int checks;
    int failures;
    int done_cnt0;
    int done_cnt1;
    int pushes0;
    int bcnt0;
    int bcnt1;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0;
    exp_t e1;

    antares_divider #(.ENABLE_EARLY_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (op_divs),
        .op_divu   (op_divu),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    antares_divider #(.ENABLE_EARLY_OUT(1'b0)) dut_ne (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (1'b0),
        .op_divu   (op_divu_ne),
        .flush     (1'b0),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient_ne),
        .remainder (remainder_ne),
        .busy      (busy_ne),
        .done      (done_ne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor for the early-out instance.
    always @(negedge clk) begin
        if (rst) begin
            bcnt0 = 0;
        end else if (done) begin
            if (sb0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done q=%h r=%h expected no result", quotient, remainder);
            end else begin
                e0 = sb0.pop_front();
                chk("quotient", quotient, e0.q);
                chk("remainder", remainder, e0.r);
                chk("busy_cycles", 32'(bcnt0), 32'(e0.lat));
            end
            done_cnt0++;
            bcnt0 = 0;
        end else if (busy) begin
            bcnt0++;
        end else begin
            bcnt0 = 0;
        end
    end

    // Monitor for the fixed-latency instance.
    always @(negedge clk) begin
        if (rst) begin
            bcnt1 = 0;
        end else if (done_ne) begin
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_ne q=%h r=%h expected no result", quotient_ne, remainder_ne);
            end else begin
                e1 = sb1.pop_front();
                chk("quotient_ne", quotient_ne, e1.q);
                chk("remainder_ne", remainder_ne, e1.r);
                chk("busy_cycles_ne", 32'(bcnt1), 32'(e1.lat));
            end
            done_cnt1++;
            bcnt1 = 0;
        end else if (busy_ne) begin
            bcnt1++;
        end else begin
            bcnt1 = 0;
        end
    end

    task automatic issue(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eq, input logic [31:0] er, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.lat = lat;
            sb0.push_back(e);
            pushes0++;
        end
        op_divs  = s;
        op_divu  = u;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        op_divs = 1'b0;
        op_divu = 1'b0;
    endtask

    task automatic wait_done0(input int target);
        int n;
        n = 0;
        while (done_cnt0 < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt0 < target) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt0, target);
        end
    endtask

    task automatic run0(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int lat);
        int target;
        target = done_cnt0 + 1;
        issue(s, u, a, b, 1'b1, eq, er, lat);
        wait_done0(target);
    endtask

    initial begin
        exp_t e;
        int   target;
        int   n;
        checks    = 0;
        failures  = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
        pushes0   = 0;
        bcnt0     = 0;
        bcnt1     = 0;
        rst        = 1'b0;
        op_divs    = 1'b0;
        op_divu    = 1'b0;
        op_divu_ne = 1'b0;
        flush      = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        #1 rst = 1'b1;
        #2;
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run0(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 8);
        run0(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4);
        run0(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        run0(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run0(1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        run0(1'b1, 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1);
        // Both start strobes: the signed interpretation must win.
        run0(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4);

        // Flush on the third busy cycle of 1000/3.
        issue(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 0);
        chk("flush_busy_c1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_hold_q", quotient, 32'hFFFF_FFFD);
        chk("flush_hold_r", remainder, 32'hFFFF_FFFF);
        repeat (15) @(posedge clk);
        #1;
        chk("flush_no_done", 32'(done_cnt0), 32'(pushes0));
        run0(1'b0, 1'b1, 32'd9, 32'd4, 32'd2, 32'd1, 5);

        // Flush together with a start in IDLE: nothing starts.
        @(posedge clk); #1;
        flush    = 1'b1;
        op_divu  = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk); #1;
        flush   = 1'b0;
        op_divu = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_start_q", quotient, 32'd2);

        // A second start while busy is dropped: exactly one done.
        target = done_cnt0 + 1;
        issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 8);
        op_divu  = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk); #1;
        op_divu = 1'b0;
        wait_done0(target);
        repeat (15) @(posedge clk);
        #1;
        chk("busy_start_one_done", 32'(done_cnt0), 32'(target));

        // Asynchronous reset in the middle of a long run.
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt0), 32'(pushes0));

        // Early-out disabled: always 32 iterations.
        @(posedge clk); #1;
        e.q   = 32'd14;
        e.r   = 32'd2;
        e.lat = 33;
        sb1.push_back(e);
        op_divu_ne = 1'b1;
        dividend   = 32'd100;
        divisor    = 32'd7;
        @(posedge clk); #1;
        op_divu_ne = 1'b0;
        n = 0;
        while (done_cnt1 < 1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("ne_done_count", 32'(done_cnt1), 32'd1);

        repeat (3) @(posedge clk);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
